// File: rtl/synth_proto_pkg.sv
// Purpose: shared framing constants, command/error encodings and image helpers for the MCU synth link.
// Latency: n/a (package).
// Backpressure: n/a (package).
package synth_proto_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [7:0] {
        CMD_WAVEGEN    = 8'h10,
        CMD_MASTER_VOL = 8'h20,
        CMD_REVERB     = 8'h30,
        CMD_PAN        = 8'h40,
        CMD_RESET_ALL  = 8'h50
    } cmd_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CSUM    = 2'd1,
        ERR_CMD     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_e;

    localparam int MV_BYTES     = 4;
    localparam int REVERB_BYTES = 52;
    localparam int PAN_BYTES    = 4;
    // Bits below the wavegen array: master_volume, reverb, pan.
    localparam int TAIL_W       = (MV_BYTES + REVERB_BYTES + PAN_BYTES) * 8;
    localparam int SHAPE_SIN    = 2;
    // Upper bound on the flat image width handled by reset_image().
    localparam int IMG_MAX_W    = 16384;

    function automatic int wg_bytes(input int env_len);
        return 10 + 2 * env_len;
    endfunction

    function automatic logic is_cmd(input logic [7:0] cmd);
        return (cmd == CMD_WAVEGEN) || (cmd == CMD_MASTER_VOL) || (cmd == CMD_REVERB) ||
               (cmd == CMD_PAN) || (cmd == CMD_RESET_ALL);
    endfunction

    function automatic int payload_len(input logic [7:0] cmd, input int env_len);
        case (cmd)
            CMD_WAVEGEN:    return wg_bytes(env_len);
            CMD_MASTER_VOL: return MV_BYTES;
            CMD_REVERB:     return REVERB_BYTES;
            CMD_PAN:        return PAN_BYTES;
            default:        return 0;
        endcase
    endfunction

    // Everything zero except each wavegen's shape byte (second-lowest byte of a slot) = SIN.
    function automatic logic [IMG_MAX_W-1:0] reset_image(input int n_osc, input int env_len);
        logic [IMG_MAX_W-1:0] img;
        img = '0;
        for (int i = 0; i < n_osc; i++) begin
            img[TAIL_W + i * wg_bytes(env_len) * 8 + 8 +: 8] = 8'(SHAPE_SIN);
        end
        return img;
    endfunction

endpackage

// File: rtl/synth_frame_loader_image.sv
// Purpose: active synth parameter image; applies a verified staged payload to its field on commit.
// Latency: written on the commit cycle edge, visible on synth image the following cycle.
// Backpressure: none; commit is a single-cycle strobe from the parser.
// Ports: clk/rst, commit strobe, cmd/index of the frame, stage (payload in its low bits), image out.
module synth_image_regs
    import synth_proto_pkg::*;
#(
    parameter  int N_OSC   = 8,
    parameter  int ENV_LEN = 8,
    parameter  int STAGE_W = 416,
    localparam int WG_W    = wg_bytes(ENV_LEN) * 8,
    localparam int SYNTH_W = N_OSC * WG_W + TAIL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               commit,
    input  logic [7:0]         cmd,
    input  logic [7:0]         index,
    input  logic [STAGE_W-1:0] stage,
    output logic [SYNTH_W-1:0] image
);

    localparam logic [IMG_MAX_W-1:0] RESET_FULL = reset_image(N_OSC, ENV_LEN);
    localparam logic [SYNTH_W-1:0]   RESET_IMG  = RESET_FULL[SYNTH_W-1:0];

    logic [SYNTH_W-1:0] image_q;
    logic [SYNTH_W-1:0] image_d;

    // Slot 0 sits at the MSB end; master_volume, reverb, pan follow towards the LSB.
    always_comb begin
        image_d = image_q;
        if (commit) begin
            case (cmd)
                CMD_WAVEGEN: begin
                    for (int i = 0; i < N_OSC; i++) begin
                        if (index == 8'(i)) begin
                            image_d[TAIL_W + (N_OSC - 1 - i) * WG_W +: WG_W] = stage[WG_W-1:0];
                        end
                    end
                end
                CMD_MASTER_VOL: image_d[TAIL_W-1 -: 32]   = stage[31:0];
                CMD_REVERB:     image_d[32 +: 416]        = stage[415:0];
                CMD_PAN:        image_d[31:0]             = stage[31:0];
                CMD_RESET_ALL:  image_d                   = RESET_IMG;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            image_q <= RESET_IMG;
        end else begin
            image_q <= image_d;
        end
    end

    assign image = image_q;

endmodule

// File: rtl/synth_frame_loader.sv
// Purpose: parses SYNC/CMD/INDEX/payload/CSUM frames from the MCU byte link and commits verified payloads.
// Latency: update one cycle after the CSUM byte is accepted; new synth_out two cycles after.
// Backpressure: in_ready drops only during the single COMMIT cycle.
// Ports: in_data/in_valid/in_ready byte stream, synth_out image, update/frame_err pulses, err_code, busy.
module synth_frame_loader
    import synth_proto_pkg::*;
#(
    parameter  int N_OSC          = 8,
    parameter  int ENV_LEN        = 8,
    parameter  int TIMEOUT_CYCLES = 100000,
    localparam int WG_BYTES       = wg_bytes(ENV_LEN),
    localparam int SYNTH_W        = N_OSC * WG_BYTES * 8 + 32 + 416 + 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [SYNTH_W-1:0] synth_out,
    output logic               update,
    output logic               frame_err,
    output logic [1:0]         err_code,
    output logic               busy
);

    localparam int STAGE_BYTES = (WG_BYTES > REVERB_BYTES) ? WG_BYTES : REVERB_BYTES;
    localparam int STAGE_W     = STAGE_BYTES * 8;

    typedef enum logic [2:0] {
        ST_SYNC, ST_CMD, ST_INDEX, ST_PAYLOAD, ST_CSUM, ST_COMMIT
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           cmd_q, cmd_d;
    logic [7:0]           index_q, index_d;
    logic [15:0]          remain_q, remain_d;
    logic [7:0]           csum_q, csum_d;
    logic [STAGE_W-1:0]   stage_q, stage_d;
    logic [31:0]          tmo_q, tmo_d;
    logic                 frame_err_q, frame_err_d;
    err_e                 err_code_q, err_code_d;
    logic                 accept;
    logic                 in_frame;
    logic                 timeout;

    assign in_ready = (state_q != ST_COMMIT);
    assign accept   = in_valid && in_ready;
    assign in_frame = (state_q == ST_CMD) || (state_q == ST_INDEX) ||
                      (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
    // An accepted byte in the expiring cycle keeps the frame alive.
    assign timeout  = in_frame && !accept && (tmo_q == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        index_d     = index_q;
        remain_d    = remain_q;
        csum_d      = csum_q;
        stage_d     = stage_q;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        tmo_d       = (in_frame && !accept) ? tmo_q + 32'd1 : 32'd0;

        case (state_q)
            ST_SYNC: begin
                csum_d = 8'h00;
                if (accept && in_data == SYNC_BYTE) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (accept) begin
                    if (!is_cmd(in_data)) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CMD;
                        state_d     = ST_SYNC;
                    end else begin
                        cmd_d    = in_data;
                        remain_d = 16'(payload_len(in_data, ENV_LEN));
                        csum_d   = csum_q ^ in_data;
                        state_d  = ST_INDEX;
                    end
                end
            end
            ST_INDEX: begin
                if (accept) begin
                    index_d = in_data;
                    csum_d  = csum_q ^ in_data;
                    if (cmd_q == CMD_WAVEGEN && 32'(in_data) >= 32'(N_OSC)) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CMD;
                        state_d     = ST_SYNC;
                    end else if (remain_q == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    // MSB-first stream: after the last byte the field sits in the low bits.
                    stage_d  = {stage_q[STAGE_W-9:0], in_data};
                    csum_d   = csum_q ^ in_data;
                    remain_d = remain_q - 16'd1;
                    if (remain_q == 16'd1) state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d = ST_COMMIT;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                        state_d     = ST_SYNC;
                    end
                end
            end
            ST_COMMIT: state_d = ST_SYNC;
            default:   state_d = ST_SYNC;
        endcase

        if (timeout) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
            state_d     = ST_SYNC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SYNC;
            cmd_q       <= '0;
            index_q     <= '0;
            remain_q    <= '0;
            csum_q      <= '0;
            stage_q     <= '0;
            tmo_q       <= '0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            index_q     <= index_d;
            remain_q    <= remain_d;
            csum_q      <= csum_d;
            stage_q     <= stage_d;
            tmo_q       <= tmo_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    synth_image_regs #(
        .N_OSC   (N_OSC),
        .ENV_LEN (ENV_LEN),
        .STAGE_W (STAGE_W)
    ) u_image (
        .clk    (clk),
        .rst    (rst),
        .commit (state_q == ST_COMMIT),
        .cmd    (cmd_q),
        .index  (index_q),
        .stage  (stage_q),
        .image  (synth_out)
    );

    assign update    = (state_q == ST_COMMIT);
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign busy      = (state_q != ST_SYNC);

endmodule

// File: tb/tb_synth_frame_loader.sv
`timescale 1ns/1ps
module tb_synth_frame_loader;

    localparam int N_OSC   = 8;
    localparam int ENV_LEN = 8;
    localparam int TMO     = 1000;
    localparam int WGB     = 10 + 2 * ENV_LEN;
    localparam int NB      = N_OSC * WGB + 4 + 52 + 4;
    localparam int SW      = NB * 8;
    localparam int MV_OFF  = N_OSC * WGB;
    localparam int RV_OFF  = MV_OFF + 4;
    localparam int PAN_OFF = RV_OFF + 52;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [SW-1:0] synth_out;
    logic          update;
    logic          frame_err;
    logic [1:0]    err_code;
    logic          busy;

    always #5 clk = ~clk;

    synth_frame_loader #(
        .N_OSC          (N_OSC),
        .ENV_LEN        (ENV_LEN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .synth_out (synth_out),
        .update    (update),
        .frame_err (frame_err),
        .err_code  (err_code),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural model ----------------
    byte unsigned m_img[NB];       // image as bytes in struct order (byte 0 = most significant)
    byte unsigned frm[$];          // bytes of the frame collected so far
    byte unsigned pend_pl[$];
    byte unsigned pend_cmd, pend_idx;
    bit           m_commit = 0;
    bit           m_err_pulse = 0;
    int           m_err_code = 0;
    int           idle = 0;
    bit           started = 0;
    int           cyc = 0;
    int           last_acc = 0;
    int           upd_seen = 0;
    int           err3_cyc = 0;
    byte unsigned pl[$];           // payload for the next send_frame

    function automatic int plen(input byte unsigned c);
        case (c)
            8'h10:   return WGB;
            8'h20:   return 4;
            8'h30:   return 52;
            8'h40:   return 4;
            8'h50:   return 0;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset_img();
        for (int i = 0; i < NB; i++) m_img[i] = 8'h00;
        for (int s = 0; s < N_OSC; s++) m_img[s * WGB + WGB - 2] = 8'd2;
    endtask

    task automatic model_err(input int code);
        m_err_pulse = 1;
        m_err_code  = code;
        frm.delete();
    endtask

    task automatic model_apply();
        int base;
        if (pend_cmd == 8'h50) begin
            model_reset_img();
        end else begin
            case (pend_cmd)
                8'h10:   base = pend_idx * WGB;
                8'h20:   base = MV_OFF;
                8'h30:   base = RV_OFF;
                default: base = PAN_OFF;
            endcase
            for (int k = 0; k < pend_pl.size(); k++) m_img[base + k] = pend_pl[k];
        end
    endtask

    task automatic model_byte(input byte unsigned b);
        int n;
        byte unsigned x;
        if (frm.size() == 0) begin
            if (b == 8'hA5) frm.push_back(b);
        end else begin
            frm.push_back(b);
            n = frm.size();
            if (n == 2 && plen(b) < 0) begin
                model_err(2);
            end else if (n == 3 && frm[1] == 8'h10 && b >= N_OSC) begin
                model_err(2);
            end else if (n >= 4 && n == plen(frm[1]) + 4) begin
                x = 8'h00;
                for (int i = 1; i <= n - 2; i++) x = x ^ frm[i];
                if (x == b) begin
                    m_commit = 1;
                    pend_cmd = frm[1];
                    pend_idx = frm[2];
                    pend_pl.delete();
                    for (int i = 3; i <= n - 2; i++) pend_pl.push_back(frm[i]);
                    frm.delete();
                end else begin
                    model_err(1);
                end
            end
        end
    endtask

    always @(posedge clk) begin
        bit acc;
        cyc++;
        started     = 1;
        m_err_pulse = 0;
        if (rst) begin
            model_reset_img();
            frm.delete();
            m_commit   = 0;
            m_err_code = 0;
            idle       = 0;
        end else begin
            acc = in_valid && !m_commit;
            if (m_commit) begin
                model_apply();
                m_commit = 0;
            end
            if (acc) begin
                last_acc = cyc;
                idle     = 0;
                model_byte(in_data);
            end else if (frm.size() > 0) begin
                idle++;
                if (idle == TMO) model_err(3);
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] dut_byte(input int k);
        return synth_out[SW - 1 - 8 * k -: 8];
    endfunction

    function automatic logic [31:0] dut_word(input int off);
        return {dut_byte(off), dut_byte(off + 1), dut_byte(off + 2), dut_byte(off + 3)};
    endfunction

    function automatic logic [31:0] m_word(input int off);
        return {m_img[off], m_img[off + 1], m_img[off + 2], m_img[off + 3]};
    endfunction

    always @(negedge clk) begin
        int diff;
        if (started) begin
            chk("update", 32'(update), 32'(m_commit));
            chk("in_ready", 32'(in_ready), 32'(!m_commit));
            chk("busy", 32'(busy), 32'(frm.size() > 0 || m_commit));
            chk("frame_err", 32'(frame_err), 32'(m_err_pulse));
            chk("err_code", 32'(err_code), 32'(m_err_code));
            diff = -1;
            for (int k = 0; k < NB; k++) begin
                if (diff < 0 && dut_byte(k) !== m_img[k]) diff = k;
            end
            total++;
            if (diff >= 0) begin
                bad++;
                $display("FAIL image byte %0d: got=%h expected=%h (cycle %0d)",
                         diff, dut_byte(diff), m_img[diff], cyc);
            end
            if (update === 1'b1) upd_seen++;
            if (frame_err === 1'b1 && err_code === 2'd3) err3_cyc = cyc;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            total++;
            bad++;
            $display("FAIL in_ready stuck low: got=0 expected=1");
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input byte unsigned cmd, input byte unsigned idx, input bit bad_csum);
        byte unsigned x;
        x = cmd ^ idx;
        send_byte(8'hA5, $urandom_range(0, 1));
        send_byte(cmd, $urandom_range(0, 1));
        send_byte(idx, $urandom_range(0, 1));
        foreach (pl[i]) begin
            x = x ^ pl[i];
            send_byte(pl[i], $urandom_range(0, 2));
        end
        send_byte(bad_csum ? (x ^ 8'h01) : x, 0);
    endtask

    task automatic wg_payload();
        pl.delete();
        pl = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
        for (int i = 0; i < 2 * ENV_LEN + 2; i++) pl.push_back(8'h00);
    endtask

    initial begin
        int u0;
        int c;
        int r;
        int idx;
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset master_volume", dut_word(MV_OFF), 32'h0);
        chk("reset shape slot0", 32'(dut_byte(WGB - 2)), 32'd2);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);

        // Master volume 0x00001000, CSUM 0x30.
        u0 = upd_seen;
        pl = '{8'h00, 8'h00, 8'h10, 8'h00};
        send_frame(8'h20, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        chk("mv update count", 32'(upd_seen - u0), 32'd1);
        chk("mv value", dut_word(MV_OFF), 32'h0000_1000);
        chk("model mv value", m_word(MV_OFF), 32'h0000_1000);
        chk("mv err_code", 32'(err_code), 32'd0);

        // Same frame, CSUM 0x31.
        u0 = upd_seen;
        send_frame(8'h20, 8'h00, 1'b1);
        repeat (3) @(negedge clk);
        chk("bad csum update count", 32'(upd_seen - u0), 32'd0);
        chk("bad csum err_code", 32'(err_code), 32'd1);
        chk("bad csum mv kept", dut_word(MV_OFF), 32'h0000_1000);

        // Wavegen slot 3.
        wg_payload();
        send_frame(8'h10, 8'h03, 1'b0);
        repeat (3) @(negedge clk);
        chk("wg3 freq", dut_word(3 * WGB), 32'h0100_0000);
        chk("wg3 velocity", dut_word(3 * WGB + 4), 32'h0000_00FF);
        chk("wg3 shape", 32'(dut_byte(3 * WGB + WGB - 2)), 32'd0);
        chk("wg2 shape kept", 32'(dut_byte(2 * WGB + WGB - 2)), 32'd2);
        chk("wg4 shape kept", 32'(dut_byte(4 * WGB + WGB - 2)), 32'd2);

        // Out-of-range slot: error right after INDEX, rest of frame discarded.
        u0 = upd_seen;
        send_byte(8'hA5, 0);
        send_byte(8'h10, 0);
        send_byte(8'h08, 0);
        chk("bad index err_code", 32'(err_code), 32'd2);
        chk("bad index busy", 32'(busy), 32'd0);
        foreach (pl[i]) send_byte(pl[i], 0);
        send_byte(8'hE6, 0);
        repeat (3) @(negedge clk);
        chk("bad index update count", 32'(upd_seen - u0), 32'd0);

        // Timeout after A5 20 00, then recovery.
        send_byte(8'hA5, 0);
        send_byte(8'h20, 0);
        send_byte(8'h00, 0);
        repeat (TMO + 50) @(negedge clk);
        chk("timeout err_code", 32'(err_code), 32'd3);
        chk("timeout distance", 32'(err3_cyc - last_acc), 32'(TMO));
        pl = '{8'h12, 8'h34, 8'h56, 8'h78};
        send_frame(8'h20, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        chk("post-timeout mv", dut_word(MV_OFF), 32'h1234_5678);

        // RESET_ALL.
        u0 = upd_seen;
        pl.delete();
        send_frame(8'h50, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset_all update count", 32'(upd_seen - u0), 32'd1);
        chk("reset_all mv", dut_word(MV_OFF), 32'h0);
        chk("reset_all wg3 shape", 32'(dut_byte(3 * WGB + WGB - 2)), 32'd2);
        chk("reset_all wg3 freq", dut_word(3 * WGB), 32'h0);

        // rst in the middle of a payload.
        pl = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
        send_frame(8'h40, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        chk("pan value", dut_word(PAN_OFF), 32'hCAFE_BABE);
        u0 = upd_seen;
        send_byte(8'hA5, 0);
        send_byte(8'h10, 0);
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid-frame rst busy", 32'(busy), 32'd0);
        chk("mid-frame rst update count", 32'(upd_seen - u0), 32'd0);
        chk("mid-frame rst pan", dut_word(PAN_OFF), 32'h0);

        // Randomised frames, including bad commands, bad slots, bad checksums and junk.
        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(0, 5) == 0) send_byte(8'($urandom_range(0, 255)), 0);
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: c = 8'h10;
                4, 9:       c = 8'h20;
                5:          c = 8'h30;
                6:          c = 8'h40;
                7:          c = 8'h50;
                default:    c = 8'h33;
            endcase
            idx = (c == 8'h10) ? $urandom_range(0, 9) : $urandom_range(0, 255);
            n = (plen(8'(c)) < 0) ? 4 : plen(8'(c));
            pl.delete();
            for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
            send_frame(8'(c), 8'(idx), $urandom_range(0, 7) == 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        // Let any frame left open by junk bytes time out under the model's eye.
        repeat (TMO + 20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        bad++;
        $display("FAIL global time limit: got=expired expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/synth_frame_loader.md
Name: synth_frame_loader

Overview:
- Byte-stream receiver between the MCU link (SPI slave byte output) and the synth datapath.
- Parses framed write commands and stages each payload.
- Commits a payload atomically into the active synth parameter image only when its XOR checksum matches. No partially written parameter ever reaches the datapath.
- Parametrised successor of the fixed synth_t register image: oscillator count and envelope length are generics, and the block adds framing, per-field addressing, integrity checking and timeout resync.

Parameters:
- N_OSC, 8, number of wavegen slots.
- ENV_LEN, 8, envelope segments per wavegen (2 bytes each: rate, duration).
- TIMEOUT_CYCLES, 100000, idle clocks inside a frame before the frame is aborted.
- WG_BYTES, 10+2*ENV_LEN, derived; wavegen payload size (freq 4, velocity 4, envelopes, shape 1, cmds 1).
- SYNTH_W, N_OSC*WG_BYTES*8+32+416+32, derived; width of synth_out.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_data  in  8  received byte
- in_valid  in  1  in_data valid; a byte is accepted when in_valid && in_ready
- in_ready  out  1  loader can accept a byte
- synth_out  out  SYNTH_W  active image; field order and packing identical to synth_t: wave_gens[0..N_OSC-1], master_volume, reverb, pan
- update  out  1  one-cycle pulse, synth_out changed this cycle
- frame_err  out  1  one-cycle pulse on frame rejection
- err_code  out  2  0 none, 1 checksum, 2 bad cmd/index, 3 timeout; holds until the next error or reset
- busy  out  1  FSM not in SYNC

Behaviour:
- Frame format: SYNC(0xA5), CMD, INDEX, payload (length set by CMD), CSUM.
- CSUM = XOR of CMD, INDEX and all payload bytes.
- Multi-byte fields are sent MSB first; the payload byte order equals the packed struct order.
- Commands and payload lengths:
  - 0x10 WAVEGEN: WG_BYTES; INDEX selects the slot.
  - 0x20 MASTER_VOL: 4.
  - 0x30 REVERB: 52 (tau[0..5], then gain[0..6]).
  - 0x40 PAN: 4.
  - 0x50 RESET_ALL: 0.
  - For every command except WAVEGEN, INDEX is ignored but still included in CSUM.
- FSM states: SYNC, CMD, INDEX, PAYLOAD, CSUM, COMMIT.
  - SYNC: discard bytes until 0xA5, then go to CMD.
  - CMD: an unknown CMD → err 2, return to SYNC. Otherwise latch CMD, load payload length, go to INDEX.
  - INDEX: for WAVEGEN with INDEX >= N_OSC → err 2, return to SYNC. Otherwise go to PAYLOAD, or to CSUM when length is 0.
  - PAYLOAD: shift bytes into a staging buffer of max(52, WG_BYTES) bytes; a down-counter counts bytes; at the last byte go to CSUM.
  - CSUM: on match go to COMMIT; on mismatch err 1, return to SYNC, active image untouched.
  - COMMIT: exactly one cycle. in_ready=0. The staged bytes are written to the addressed field, update=1 in that same cycle, and synth_out shows the new value from the next cycle. Then go to SYNC.
- Latency: update asserts 1 cycle after the CSUM byte is accepted; the new synth_out is visible 2 cycles after.
- in_ready = 1 in every state except COMMIT.
- RESET_ALL commit: the image is set to reset values. Every field is 0 except wave_gens[i].shape = SIN (2).
- Timeout:
  - The counter clears on every accepted byte and in SYNC.
  - In CMD/INDEX/PAYLOAD/CSUM, when the counter reaches TIMEOUT_CYCLES → err 3, return to SYNC, staged data discarded.
  - If a byte is accepted in the same cycle the count would expire, the byte wins and no timeout fires.
- A 0xA5 byte in the middle of a frame is treated as data (no resync); only an error or timeout returns the FSM to SYNC.
- Reset values:
  - synth_out at reset values (as for RESET_ALL).
  - update=0, frame_err=0, err_code=0, busy=0, in_ready=1, FSM in SYNC, counters 0.
  - Reset in the middle of a frame discards the frame; no update pulse is generated.

Decomposition:
- synth_proto_pkg holds:
  - SYNC_BYTE.
  - cmd_e (CMD_WAVEGEN, CMD_MASTER_VOL, CMD_REVERB, CMD_PAN, CMD_RESET_ALL).
  - err_e.
  - Functions wg_bytes(env_len) and payload_len(cmd, env_len).
  - The reset-value function for a flat image.
- One sub-module: synth_image_regs. It holds the SYNTH_W active register and, on commit, applies the staged bytes plus command/index to the correct bit slice. The parser FSM stays in the top module.

Test Plan:
- Send A5 20 00 00 00 10 00 30 → update pulse once; master_volume=0x00001000; err_code 0.
- Same frame with CSUM 0x31 → frame_err pulse, err_code=1, master_volume unchanged, no update.
- WAVEGEN, INDEX 3, freq 0x01000000, velocity 0xFF, shape 0 → only wave_gens[3] changes; slots 0–2 and 4–7 unchanged.
- Same frame with INDEX 8 (N_OSC=8) → err_code=2 after the INDEX byte; the following bytes are discarded until the next 0xA5.
- With TIMEOUT_CYCLES=1000: send A5 20 00, then idle → err_code=3 exactly 1000 cycles after the last byte; a following valid MASTER_VOL frame commits correctly.
- Send RESET_ALL (A5 50 00 50) after loading values → all fields 0, all shapes=2. Separately, assert rst mid-PAYLOAD → busy=0, no update pulse, image at reset values.
